add_sub_accumulator: RTL and testbench

ADD_SUB_ACCUMULATOR -- requirements
Module: add_sub_accumulator

---
 rtl/add_sub_pkg.sv | 9 +
 rtl/adder_subtractor.sv | 25 ++
 rtl/add_sub_accumulator.sv | 113 +++++++++++
 tb/tb_add_sub_accumulator.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared constants and FSM state encoding for the add/sub accumulator.
package add_sub_pkg;
    localparam int DATA_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;
endpackage

// File: rtl/adder_subtractor.sv
// Combinational 4-bit adder/subtractor: s = a + b (k=0) or a + ~b + 1 (k=1).
module adder_subtractor
    import add_sub_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              k,
    output logic [DATA_W-1:0] s,
    output logic              cout,
    output logic              ovf
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;

    always_comb begin
        b_eff = k ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, k};
        s     = sum[DATA_W-1:0];
        cout  = sum[DATA_W];
        // overflow: effective operand signs agree but the result sign differs
        ovf   = (a[DATA_W-1] == b_eff[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
    end

endmodule

// File: rtl/add_sub_accumulator.sv
// Handshaked add/subtract accumulator with operation counter.
// Optional clamping of out_acc when ACC_SATURATE_EN is defined.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// RESP  | result registered, out_valid high until the consumer takes it
module add_sub_accumulator
    import add_sub_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_k,
    input  logic              in_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_acc,
    output logic              out_cout,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  op_count
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] sum_s;
    logic              sum_cout;
    logic              sum_ovf;
    logic [DATA_W-1:0] res;
    logic              accept;

    adder_subtractor u_addsub (
        .a    (acc_q),
        .b    (in_data),
        .k    (in_k),
        .s    (sum_s),
        .cout (sum_cout),
        .ovf  (sum_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RESP;
            RESP:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept = in_valid && (state_q == IDLE);
`ifdef ACC_SATURATE_EN
        // flags stay raw; only the stored value is clamped
        if (!in_k && sum_cout)
            res = {DATA_W{1'b1}};
        else if (in_k && !sum_cout)
            res = '0;
        else
            res = sum_s;
`else
        res = sum_s;
`endif
        acc_d  = acc_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        cnt_d  = cnt_q;
        if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (in_clr) begin
                acc_d  = in_data;
                cout_d = 1'b0;
                ovf_d  = 1'b0;
            end else begin
                acc_d  = res;
                cout_d = sum_cout;
                ovf_d  = sum_ovf;
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == RESP);
        out_acc   = acc_q;
        out_cout  = cout_q;
        out_ovf   = ovf_q;
        op_count  = cnt_q;
    end

endmodule

// File: tb/tb_add_sub_accumulator.sv
// Randomized and directed bench for add_sub_accumulator against a plain-arithmetic model.
module tb_add_sub_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       in_k = 1'b0;
    logic       in_clr = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, out_cout, out_ovf;
    logic [3:0] out_acc;
    logic [7:0] op_count;

    logic       in_ready2, out_valid2, out_cout2, out_ovf2;
    logic [3:0] out_acc2;
    logic [1:0] op_count2;

    int vec  = 0;
    int errs = 0;

    int m_acc  = 0;
    int m_cout = 0;
    int m_ovf  = 0;
    int m_cnt  = 0;

    always #5 clk = ~clk;

    add_sub_accumulator #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_k(in_k), .in_clr(in_clr), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc(out_acc), .out_cout(out_cout),
        .out_ovf(out_ovf), .op_count(op_count)
    );

    add_sub_accumulator #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_k(in_k), .in_clr(in_clr), .out_valid(out_valid2),
        .out_ready(out_ready), .out_acc(out_acc2), .out_cout(out_cout2),
        .out_ovf(out_ovf2), .op_count(op_count2)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: signed/unsigned arithmetic on integers, no bit-level adder.
    function automatic void model_op(input int b, input int k, input int clr);
        int sa, sb, sr, raw;
        if (clr != 0) begin
            m_acc = b; m_cout = 0; m_ovf = 0;
        end else begin
            sa = (m_acc >= 8) ? m_acc - 16 : m_acc;
            sb = (b >= 8) ? b - 16 : b;
            if (k == 0) begin
                raw    = m_acc + b;
                m_cout = (raw >= 16) ? 1 : 0;
                sr     = sa + sb;
            end else begin
                raw    = m_acc - b + 16;
                m_cout = (m_acc >= b) ? 1 : 0;
                sr     = sa - sb;
            end
            m_ovf = (sr > 7 || sr < -8) ? 1 : 0;
            m_acc = raw % 16;
`ifdef ACC_SATURATE_EN
            if (k == 0 && m_cout == 1) m_acc = 15;
            if (k == 1 && m_cout == 0) m_acc = 0;
`endif
        end
        m_cnt = m_cnt + 1;
    endfunction

    task automatic drive_op(input int b, input int k, input int clr);
        int t;
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'(b); in_k = k[0]; in_clr = clr[0]; out_ready = 1'b0;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
            errs++;
        end
        vec++;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_data = 4'($urandom); in_k = 1'($urandom); in_clr = 1'($urandom);
        model_op(b, k, clr);
    endtask

    task automatic take_result();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_clr = 1'b1; in_data = 4'($urandom);
        @(posedge clk);
        #1;
        out_ready = 1'b0; in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 4'hA; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        m_acc = 0; m_cout = 0; m_ovf = 0; m_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid actual=%0b required=0", out_valid); errs++; end vec++;
        if (in_ready !== 1'b1) begin $display("FAIL rst_in_ready actual=%0b required=1", in_ready); errs++; end vec++;
        if (out_acc !== 4'h0) begin $display("FAIL rst_acc actual=%0h required=0", out_acc); errs++; end vec++;
        if ({out_cout, out_ovf} !== 2'b00) begin $display("FAIL rst_flags actual=%b required=00", {out_cout, out_ovf}); errs++; end vec++;
        if (op_count !== 8'd0) begin $display("FAIL rst_count actual=%0d required=0", op_count); errs++; end vec++;
    endtask

    task automatic test_directed();
        logic [3:0] exp_wrap_add, exp_wrap_sub;
`ifdef ACC_SATURATE_EN
        exp_wrap_add = 4'hF; exp_wrap_sub = 4'h0;
`else
        exp_wrap_add = 4'h0; exp_wrap_sub = 4'hF;
`endif
        do_reset();
        drive_op(1, 0, 1); take_result();
        drive_op(2, 0, 0);
        if ({out_acc, out_cout, out_ovf} !== {4'd3, 2'b00}) begin $display("FAIL dir_clr_add actual=%h/%b%b required=3/00", out_acc, out_cout, out_ovf); errs++; end vec++;
        if (op_count !== 8'd2) begin $display("FAIL dir_count actual=%0d required=2", op_count); errs++; end vec++;
        take_result();
        drive_op(6, 0, 1); take_result();
        drive_op(1, 1, 0);
        if ({out_acc, out_cout, out_ovf} !== {4'd5, 2'b10}) begin $display("FAIL dir_sub actual=%h/%b%b required=5/10", out_acc, out_cout, out_ovf); errs++; end vec++;
        take_result();
        drive_op(15, 0, 1); take_result();
        drive_op(1, 0, 0);
        if ({out_acc, out_cout} !== {exp_wrap_add, 1'b1}) begin $display("FAIL dir_add_top actual=%h/%b required=%h/1", out_acc, out_cout, exp_wrap_add); errs++; end vec++;
        take_result();
        drive_op(7, 0, 1); take_result();
        drive_op(1, 0, 0);
        if ({out_acc, out_cout, out_ovf} !== {4'd8, 2'b01}) begin $display("FAIL dir_ovf actual=%h/%b%b required=8/01", out_acc, out_cout, out_ovf); errs++; end vec++;
        take_result();
        drive_op(0, 0, 1); take_result();
        drive_op(1, 1, 0);
        if ({out_acc, out_cout, out_ovf} !== {exp_wrap_sub, 2'b00}) begin $display("FAIL dir_borrow actual=%h/%b%b required=%h/00", out_acc, out_cout, out_ovf, exp_wrap_sub); errs++; end vec++;
        take_result();
    endtask

    task automatic test_random();
        int b, k, clr;
        for (int i = 0; i < 60; i++) begin
            b = int'($urandom_range(15, 0));
            k = int'($urandom_range(1, 0));
            clr = ($urandom_range(7, 0) == 0) ? 1 : 0;
            drive_op(b, k, clr);
            if (out_valid !== 1'b1) begin $display("FAIL rand_valid actual=%0b required=1", out_valid); errs++; end vec++;
            if (out_acc !== 4'(m_acc)) begin $display("FAIL rand_acc actual=%0h required=%0h", out_acc, m_acc); errs++; end vec++;
            if (out_cout !== 1'(m_cout)) begin $display("FAIL rand_cout actual=%0b required=%0d", out_cout, m_cout); errs++; end vec++;
            if (out_ovf !== 1'(m_ovf)) begin $display("FAIL rand_ovf actual=%0b required=%0d", out_ovf, m_ovf); errs++; end vec++;
            if (op_count !== 8'(m_cnt)) begin $display("FAIL rand_count actual=%0d required=%0d", op_count, m_cnt % 256); errs++; end vec++;
            if ({out_acc2, out_cout2, out_ovf2, out_valid2, in_ready2} !== {4'(m_acc), 1'(m_cout), 1'(m_ovf), 2'b10}) begin
                $display("FAIL rand_dut2 actual=%h/%b%b%b%b required=%h/%0d%0d10", out_acc2, out_cout2, out_ovf2, out_valid2, in_ready2, m_acc, m_cout, m_ovf); errs++;
            end vec++;
            if (op_count2 !== 2'(m_cnt)) begin $display("FAIL rand_count2 actual=%0d required=%0d", op_count2, m_cnt % 4); errs++; end vec++;
            take_result();
            if ({out_valid, in_ready} !== 2'b01) begin $display("FAIL rand_release actual=%b required=01", {out_valid, in_ready}); errs++; end vec++;
        end
    endtask

    task automatic test_backpressure();
        int cnt0;
        drive_op(int'($urandom_range(15, 0)), 0, 0);
        cnt0 = m_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 4'($urandom); in_k = 1'($urandom); in_clr = 1'($urandom);
            @(posedge clk);
            #1;
            if ({out_valid, in_ready} !== 2'b10) begin $display("FAIL bp_hs actual=%b required=10", {out_valid, in_ready}); errs++; end vec++;
            if ({out_acc, out_cout, out_ovf} !== {4'(m_acc), 1'(m_cout), 1'(m_ovf)}) begin
                $display("FAIL bp_stable actual=%h/%b%b required=%h/%0d%0d", out_acc, out_cout, out_ovf, m_acc, m_cout, m_ovf); errs++;
            end vec++;
            if (op_count !== 8'(cnt0)) begin $display("FAIL bp_count actual=%0d required=%0d", op_count, cnt0); errs++; end vec++;
        end
        in_valid = 1'b0;
        take_result();
        if ({out_valid, in_ready} !== 2'b01) begin $display("FAIL bp_release actual=%b required=01", {out_valid, in_ready}); errs++; end vec++;
        if (op_count !== 8'(cnt0)) begin $display("FAIL bp_no_accept actual=%0d required=%0d", op_count, cnt0); errs++; end vec++;
    endtask

    task automatic test_rst_in_resp();
        drive_op(9, 0, 1);
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; out_ready = 1'b0;
        m_acc = 0; m_cout = 0; m_ovf = 0; m_cnt = 0;
        if (out_valid !== 1'b0) begin $display("FAIL rstresp_valid actual=%0b required=0", out_valid); errs++; end vec++;
        if (out_acc !== 4'h0) begin $display("FAIL rstresp_acc actual=%0h required=0", out_acc); errs++; end vec++;
        if (op_count !== 8'd0) begin $display("FAIL rstresp_count actual=%0d required=0", op_count); errs++; end vec++;
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_op(int'($urandom_range(15, 0)), int'($urandom_range(1, 0)), 0);
            if (op_count2 !== 2'((i + 1) % 4)) begin $display("FAIL wrap_count2 actual=%0d required=%0d", op_count2, (i + 1) % 4); errs++; end vec++;
            if (op_count !== 8'(i + 1)) begin $display("FAIL wrap_count actual=%0d required=%0d", op_count, i + 1); errs++; end vec++;
            take_result();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_rst_in_resp();
        test_cnt_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
